// File: rtl/fifo_frame_writer.sv
// Frame buffer that streams a loaded frame into the fifo1 write port.
// Optional trailing checksum byte: define FIFO_WRITER_CHECKSUM_EN.
module fifo_frame_writer #(
  parameter int DSIZE = 8,
  parameter int FRAME = 16,
  parameter int CW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_en,
  input  logic [DSIZE-1:0] ld_data,
  input  logic             start,
  input  logic             wfull,
  output logic [DSIZE-1:0] wdata,
  output logic             winc,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    ld_count
);

  localparam int          AW      = $clog2(FRAME);
  localparam logic [CW-1:0] FRAME_C = CW'(FRAME);

`ifdef FIFO_WRITER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, CSUM, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
`endif

  state_t              state_q;
  logic [CW-1:0]       ld_count_q;
  logic [CW-1:0]       rd_idx_q;
  logic                done_q;
  logic                busy_q;
  logic [DSIZE-1:0]    mem [FRAME];
  logic                ld_fire;
  logic [CW-1:0]       cnt_d;
  logic                last;
`ifdef FIFO_WRITER_CHECKSUM_EN
  logic [DSIZE-1:0]    acc_q;
`endif

  assign ld_fire = (state_q == IDLE) && ld_en && (ld_count_q != FRAME_C);
  assign cnt_d   = ld_count_q + CW'(ld_fire);
  assign last    = (rd_idx_q == ld_count_q - 1'b1);

  always_comb begin
    wdata = '0;
    winc  = 1'b0;
    unique case (state_q)
      SEND: begin
        wdata = mem[rd_idx_q[AW-1:0]];
        winc  = !wfull && !rst;
      end
`ifdef FIFO_WRITER_CHECKSUM_EN
      CSUM: begin
        wdata = -acc_q;
        winc  = !wfull && !rst;
      end
`endif
      default: ;
    endcase
  end

  // Buffer contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (ld_fire) mem[ld_count_q[AW-1:0]] <= ld_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ld_count_q <= '0;
      rd_idx_q   <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef FIFO_WRITER_CHECKSUM_EN
      acc_q      <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          ld_count_q <= cnt_d;
          if (start) begin
            rd_idx_q <= '0;
            if (cnt_d != '0) begin
              state_q <= SEND;
              busy_q  <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        SEND: begin
          if (winc) begin
            rd_idx_q <= rd_idx_q + 1'b1;
`ifdef FIFO_WRITER_CHECKSUM_EN
            acc_q <= acc_q + wdata;
            if (last) state_q <= CSUM;
`else
            if (last) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
`endif
          end
        end
`ifdef FIFO_WRITER_CHECKSUM_EN
        CSUM: begin
          if (winc) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
`endif
        DONE: begin
          ld_count_q <= '0;
          rd_idx_q   <= '0;
`ifdef FIFO_WRITER_CHECKSUM_EN
          acc_q      <= '0;
`endif
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ld_count = ld_count_q;

endmodule
